// File: rtl/m_useq_pkg.sv
// Purpose: shared constants, enums and microword layout for the m_useq_ctrl micro-sequencer.
// Contents: MIPS opcode/funct codes, ALU codes, microstate addresses, AddrCtl enum, uword_t,
//           plus decode helpers for the DISP1 table and the funct/opcode ALU code selection.
package m_useq_pkg;

    // Opcodes (Inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type funct codes (Inst[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Microstate addresses
    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADDR = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_REXEC   = 4'd6;
    localparam logic [3:0] ST_RDONE   = 4'd7;
    localparam logic [3:0] ST_BR      = 4'd8;
    localparam logic [3:0] ST_JMP     = 4'd9;
    localparam logic [3:0] ST_IEXEC   = 4'd10;
    localparam logic [3:0] ST_IDONE   = 4'd11;
    localparam logic [3:0] ST_JAL     = 4'd12;
    localparam logic [3:0] ST_ILLEGAL = 4'd13;

    typedef enum logic [1:0] {AC_SEQ, AC_DISP1, AC_DISP2, AC_FETCH} addr_ctl_e;

    // Where the ALU code comes from: the microword itself, the funct field or the opcode
    typedef enum logic [1:0] {ALU_FIXED, ALU_FUNCT, ALU_OPC} alu_sel_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       br_en;       // Branch follows opcode==bne only when set
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
        alu_sel_e   alu_sel;
        logic [2:0] alu_code;
        logic       wait_st;     // state waits for MIO_ready
        logic       illegal;
        addr_ctl_e  addr_ctl;
    } uword_t;

    function automatic logic [3:0] disp1(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         disp1 = ST_REXEC;
            OP_LW, OP_SW:                     disp1 = ST_MEMADDR;
            OP_BEQ, OP_BNE:                   disp1 = ST_BR;
            OP_J:                             disp1 = ST_JMP;
            OP_JAL:                           disp1 = ST_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: disp1 = ST_IEXEC;
            default:                          disp1 = ST_ILLEGAL;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_XOR:  funct_alu = ALU_XOR;
            FN_NOR:  funct_alu = ALU_NOR;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_SRL:  funct_alu = ALU_SRL;
            default: funct_alu = ALU_ADD;   // add and any unknown funct
        endcase
    endfunction

    function automatic logic [2:0] opc_alu(input logic [5:0] op);
        case (op)
            OP_ANDI: opc_alu = ALU_AND;
            OP_ORI:  opc_alu = ALU_OR;
            OP_SLTI: opc_alu = ALU_SLT;
            default: opc_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/m_useq_urom.sv
// Purpose: combinational micro-ROM, maps micro-address to microword; unused addresses read as Illegal.
// Ports: upc_i (micro-address), uword_o (microword).
// Latency: zero (pure decode); no backpressure.
module m_useq_urom
    import m_useq_pkg::*;
#(
    parameter int UADDR_W = 4
) (
    input  logic [UADDR_W-1:0] upc_i,
    output uword_t             uword_o
);

    always_comb begin
        uword_o          = '0;
        uword_o.alu_sel  = ALU_FIXED;
        uword_o.addr_ctl = AC_FETCH;
        case (upc_i)
            UADDR_W'(ST_FETCH): begin
                uword_o.mem_read  = 1'b1;
                uword_o.ir_write  = 1'b1;
                uword_o.alu_src_b = 2'b01;
                uword_o.alu_code  = ALU_ADD;
                uword_o.pc_write  = 1'b1;
                uword_o.wait_st   = 1'b1;
                uword_o.addr_ctl  = AC_SEQ;
            end
            UADDR_W'(ST_DECODE): begin
                uword_o.alu_src_b = 2'b11;
                uword_o.alu_code  = ALU_ADD;
                uword_o.addr_ctl  = AC_DISP1;
            end
            UADDR_W'(ST_MEMADDR): begin
                uword_o.alu_src_a = 1'b1;
                uword_o.alu_src_b = 2'b10;
                uword_o.alu_code  = ALU_ADD;
                uword_o.addr_ctl  = AC_DISP2;
            end
            UADDR_W'(ST_MEMRD): begin
                uword_o.mem_read = 1'b1;
                uword_o.iord     = 1'b1;
                uword_o.wait_st  = 1'b1;
                uword_o.addr_ctl = AC_SEQ;
            end
            UADDR_W'(ST_MEMWB): begin
                uword_o.mem_to_reg = 2'b01;
                uword_o.reg_write  = 1'b1;
            end
            UADDR_W'(ST_MEMWR): begin
                uword_o.mem_write = 1'b1;
                uword_o.iord      = 1'b1;
                uword_o.wait_st   = 1'b1;
            end
            UADDR_W'(ST_REXEC): begin
                uword_o.alu_src_a = 1'b1;
                uword_o.alu_sel   = ALU_FUNCT;
                uword_o.addr_ctl  = AC_SEQ;
            end
            UADDR_W'(ST_RDONE): begin
                uword_o.reg_dst   = 2'b01;
                uword_o.reg_write = 1'b1;
            end
            UADDR_W'(ST_BR): begin
                uword_o.alu_src_a     = 1'b1;
                uword_o.alu_code      = ALU_SUB;
                uword_o.pc_source     = 2'b01;
                uword_o.pc_write_cond = 1'b1;
                uword_o.br_en         = 1'b1;
            end
            UADDR_W'(ST_JMP): begin
                uword_o.pc_source = 2'b10;
                uword_o.pc_write  = 1'b1;
            end
            UADDR_W'(ST_IEXEC): begin
                uword_o.alu_src_a = 1'b1;
                uword_o.alu_src_b = 2'b10;
                uword_o.alu_sel   = ALU_OPC;
                uword_o.addr_ctl  = AC_SEQ;
            end
            UADDR_W'(ST_IDONE): begin
                uword_o.reg_write = 1'b1;
            end
            UADDR_W'(ST_JAL): begin
                uword_o.reg_dst    = 2'b10;
                uword_o.mem_to_reg = 2'b10;
                uword_o.reg_write  = 1'b1;
                uword_o.pc_source  = 2'b10;
                uword_o.pc_write   = 1'b1;
            end
            default: begin
                uword_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/m_useq_ctrl.sv
// Purpose: microprogrammed control sequencer for the multi-cycle MIPS datapath M_datapath.
// Ports: clk/reset (async active-low), Inst/zero/MIO_ready in; all datapath controls, upc, illegal_op, timeout out.
// Latency: outputs combinational from upc and Inst; one microstate per clock; MIO_ready=0 in a wait state stalls upc.
// Optional: define M_USEQ_TIMEOUT_EN to enable the stall watchdog (TIMEOUT_CYC) and sticky timeout flag.
module m_useq_ctrl
    import m_useq_pkg::*;
#(
    parameter int UADDR_W     = 4,
    parameter int ALUOP_W     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Inst,
    input  logic               zero,
    input  logic               MIO_ready,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               IorD,
    output logic               Branch,
    output logic               PCWriteCond,
    output logic               PCWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALU_operation,
    output logic [UADDR_W-1:0] upc,
    output logic               illegal_op,
    output logic               timeout
);

    logic [UADDR_W-1:0] upc_q, upc_d, upc_nxt;
    uword_t             uw;
    logic [5:0]         opcode, funct;
    logic [2:0]         alu_code;
    logic               stall, wr_en;

    assign opcode = Inst[31:26];
    assign funct  = Inst[5:0];

    m_useq_urom #(.UADDR_W(UADDR_W)) u_urom (
        .upc_i   (upc_q),
        .uword_o (uw)
    );

    assign stall = uw.wait_st & ~MIO_ready;

    always_comb begin
        upc_nxt = '0;
        case (uw.addr_ctl)
            AC_SEQ:   upc_nxt = upc_q + UADDR_W'(1);
            AC_DISP1: upc_nxt = UADDR_W'(disp1(opcode));
            AC_DISP2: upc_nxt = (opcode == OP_SW) ? UADDR_W'(ST_MEMWR) : UADDR_W'(ST_MEMRD);
            default:  upc_nxt = '0;
        endcase
    end

    always_comb begin
        alu_code = uw.alu_code;
        case (uw.alu_sel)
            ALU_FUNCT: alu_code = funct_alu(funct);
            ALU_OPC:   alu_code = opc_alu(opcode);
            default:   alu_code = uw.alu_code;
        endcase
    end

`ifdef M_USEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d, wd_fire;

    // Fires on the stalled edge that would bring the count to TIMEOUT_CYC
    assign wd_fire = stall && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        upc_d     = stall ? upc_q : upc_nxt;
        cnt_d     = stall ? cnt_q + CNT_W'(1) : '0;
        timeout_d = timeout_q;
        if (wd_fire) begin
            upc_d     = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign upc_d   = stall ? upc_q : upc_nxt;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) upc_q <= '0;
        else        upc_q <= upc_d;
    end

    // Reset kills every strobe combinationally; a stall additionally kills the state-changing writes
    assign wr_en = reset & ~stall;

    assign IRWrite       = uw.ir_write      & wr_en;
    assign RegWrite      = uw.reg_write     & wr_en;
    assign PCWrite       = uw.pc_write      & wr_en;
    assign PCWriteCond   = uw.pc_write_cond & wr_en;
    assign MemRead       = uw.mem_read      & reset;
    assign MemWrite      = uw.mem_write     & reset;
    assign Branch        = uw.br_en & (opcode == OP_BNE);
    assign ALUSrcA       = uw.alu_src_a;
    assign IorD          = uw.iord;
    assign RegDst        = uw.reg_dst;
    assign MemtoReg      = uw.mem_to_reg;
    assign ALUSrcB       = uw.alu_src_b;
    assign PCSource      = uw.pc_source;
    assign ALU_operation = ALUOP_W'(alu_code);
    assign upc           = upc_q;
    assign illegal_op    = uw.illegal & reset;

    // zero is informational only; branch resolution happens in the datapath
    logic unused_ok;
    assign unused_ok = ^{zero, Inst[25:6], (TIMEOUT_CYC != 0)};

endmodule

// File: tb/tb_m_useq_ctrl.sv
module tb_m_useq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst;
    logic        zero;
    logic        MIO_ready;
    logic        IRWrite, RegWrite, ALUSrcA, IorD, Branch, PCWriteCond, PCWrite, MemRead, MemWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [3:0]  upc;
    logic        illegal_op, timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    m_useq_ctrl #(.UADDR_W(4), .ALUOP_W(3), .TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .Inst          (Inst),
        .zero          (zero),
        .MIO_ready     (MIO_ready),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .IorD          (IorD),
        .Branch        (Branch),
        .PCWriteCond   (PCWriteCond),
        .PCWrite       (PCWrite),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .ALU_operation (ALU_operation),
        .upc           (upc),
        .illegal_op    (illegal_op),
        .timeout       (timeout)
    );

    // Leaves the DUT in Fetch at a falling edge with reset released
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Inst = 32'h8C01_0004;
        MIO_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (upc !== 4'd0) begin bad++; $display("FAIL reset_upc got=%0d exp=0", upc); end
        total++; if ({IRWrite, RegWrite, PCWrite, PCWriteCond, MemRead, MemWrite} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes got=%b exp=000000", {IRWrite, RegWrite, PCWrite, PCWriteCond, MemRead, MemWrite}); end
        total++; if (ALUSrcB !== 2'b01 || ALU_operation !== 3'b010) begin
            bad++; $display("FAIL reset_fetch_sel got=%b/%b exp=01/010", ALUSrcB, ALU_operation); end
        total++; if (illegal_op !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b exp=00", illegal_op, timeout); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (upc !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
            bad++; $display("FAIL release_fetch got=%0d/%b%b exp=0/11", upc, PCWrite, IRWrite); end
        @(negedge clk); #1;
        total++; if (upc !== 4'd1) begin bad++; $display("FAIL release_first_edge got=%0d exp=1", upc); end
    endtask

    task automatic test_lw();
        int eu[6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        Inst = 32'h8C01_0004;
        MIO_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL lw_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            total++; if (RegWrite !== (i == 4)) begin bad++; $display("FAIL lw_regwrite[%0d] got=%b exp=%b", i, RegWrite, (i == 4)); end
            if (i == 4) begin
                total++; if (MemtoReg !== 2'b01) begin bad++; $display("FAIL lw_memtoreg got=%b exp=01", MemtoReg); end
            end
            if (i == 3) begin
                total++; if (MemRead !== 1'b1 || IorD !== 1'b1) begin bad++; $display("FAIL lw_memrd got=%b%b exp=11", MemRead, IorD); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_stall();
        int eu[8]  = '{0, 1, 2, 5, 5, 5, 5, 0};
        int rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        do_reset();
        Inst = 32'hAC01_0004;
        for (int i = 0; i < 8; i++) begin
            MIO_ready = rdy[i][0];
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL sw_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            if (eu[i] == 5) begin
                total++; if (MemWrite !== 1'b1 || PCWrite !== 1'b0 || IorD !== 1'b1) begin
                    bad++; $display("FAIL sw_memwr[%0d] got=%b%b%b exp=101", i, MemWrite, PCWrite, IorD); end
            end
            @(negedge clk);
        end
        MIO_ready = 1'b1;
    endtask

    task automatic test_fetch_stall();
        do_reset();
        Inst = 32'h0000_0020;
        MIO_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++; if (upc !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 || MemRead !== 1'b1 || ALUSrcB !== 2'b01) begin
                bad++; $display("FAIL fetch_stall[%0d] got upc=%0d pcw=%b irw=%b mr=%b srcb=%b exp 0 0 0 1 01",
                                i, upc, PCWrite, IRWrite, MemRead, ALUSrcB); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL fetch_stall_timeout[%0d] got=%b exp=0", i, timeout); end
            @(negedge clk);
        end
        MIO_ready = 1'b1;
        #1;
        total++; if (PCWrite !== 1'b1) begin bad++; $display("FAIL fetch_resume_pcw got=%b exp=1", PCWrite); end
        @(negedge clk); #1;
        total++; if (upc !== 4'd1) begin bad++; $display("FAIL fetch_resume_upc got=%0d exp=1", upc); end
    endtask

    task automatic test_branch(input logic [31:0] ins, input logic exp_br);
        int eu[4] = '{0, 1, 8, 0};
        do_reset();
        Inst = ins;
        MIO_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL br_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            if (i == 2) begin
                total++; if (Branch !== exp_br || PCWriteCond !== 1'b1 || ALU_operation !== 3'b110 || PCSource !== 2'b01) begin
                    bad++; $display("FAIL br_state8 got br=%b pwc=%b alu=%b psrc=%b exp %b 1 110 01",
                                    Branch, PCWriteCond, ALU_operation, PCSource, exp_br); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        int eu[5] = '{0, 1, 6, 7, 0};
        do_reset();
        Inst = 32'h0022_1827;   // nor
        MIO_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL r_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            if (i == 2) begin
                total++; if (ALU_operation !== 3'b100 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
                    bad++; $display("FAIL r_exec got alu=%b a=%b b=%b exp 100 1 00", ALU_operation, ALUSrcA, ALUSrcB); end
                Inst = 32'h0022_182A;   // slt, same state
                #1;
                total++; if (ALU_operation !== 3'b111) begin bad++; $display("FAIL r_exec_slt got=%b exp=111", ALU_operation); end
                Inst = 32'h0022_183F;   // unknown funct
                #1;
                total++; if (ALU_operation !== 3'b010) begin bad++; $display("FAIL r_exec_dflt got=%b exp=010", ALU_operation); end
            end
            if (i == 3) begin
                total++; if (RegDst !== 2'b01 || RegWrite !== 1'b1 || MemtoReg !== 2'b00) begin
                    bad++; $display("FAIL r_done got dst=%b rw=%b m2r=%b exp 01 1 00", RegDst, RegWrite, MemtoReg); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_itype();
        int eu[5] = '{0, 1, 10, 11, 0};
        do_reset();
        Inst = 32'h3422_00FF;   // ori
        MIO_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL i_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            if (i == 2) begin
                total++; if (ALU_operation !== 3'b001 || ALUSrcB !== 2'b10) begin
                    bad++; $display("FAIL i_exec got alu=%b b=%b exp 001 10", ALU_operation, ALUSrcB); end
            end
            if (i == 3) begin
                total++; if (RegWrite !== 1'b1 || RegDst !== 2'b00) begin
                    bad++; $display("FAIL i_done got rw=%b dst=%b exp 1 00", RegWrite, RegDst); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jal();
        int eu[4] = '{0, 1, 12, 0};
        do_reset();
        Inst = 32'h0C00_0010;
        MIO_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL jal_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            if (i == 2) begin
                total++; if (RegDst !== 2'b10 || MemtoReg !== 2'b10 || PCWrite !== 1'b1 || PCSource !== 2'b10 || RegWrite !== 1'b1) begin
                    bad++; $display("FAIL jal_state got dst=%b m2r=%b pcw=%b psrc=%b rw=%b exp 10 10 1 10 1",
                                    RegDst, MemtoReg, PCWrite, PCSource, RegWrite); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        int eu[4] = '{0, 1, 13, 0};
        do_reset();
        Inst = 32'hFC00_0000;
        MIO_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (upc !== 4'(eu[i])) begin bad++; $display("FAIL ill_upc[%0d] got=%0d exp=%0d", i, upc, eu[i]); end
            total++; if (illegal_op !== (i == 2)) begin bad++; $display("FAIL ill_pulse[%0d] got=%b exp=%b", i, illegal_op, (i == 2)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        Inst = 32'h8C01_0004;
        MIO_ready = 1'b1;
        repeat (3) @(negedge clk);
        MIO_ready = 1'b0;
        #1;
        total++; if (upc !== 4'd3 || MemRead !== 1'b1) begin bad++; $display("FAIL mid_pre got upc=%0d mr=%b exp 3 1", upc, MemRead); end
        reset = 1'b0;
        #1;
        total++; if (upc !== 4'd0 || {IRWrite, RegWrite, PCWrite, PCWriteCond, MemRead, MemWrite} !== 6'b0) begin
            bad++; $display("FAIL mid_async got upc=%0d strobes=%b exp 0 000000", upc,
                            {IRWrite, RegWrite, PCWrite, PCWriteCond, MemRead, MemWrite}); end
        MIO_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (upc !== 4'd0 || RegWrite !== 1'b0) begin bad++; $display("FAIL mid_release got upc=%0d rw=%b exp 0 0", upc, RegWrite); end
        @(negedge clk);
    endtask

`ifdef M_USEQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        Inst = 32'h8C01_0004;
        MIO_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL wd_early got=%b exp=0", timeout); end
        @(negedge clk); #1;
        total++; if (timeout !== 1'b1 || upc !== 4'd0) begin bad++; $display("FAIL wd_fire got=%b upc=%0d exp 1 0", timeout, upc); end
        MIO_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", timeout); end
        do_reset();
        #1;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL wd_clear got=%b exp=0", timeout); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        zero = 1'b0;
        MIO_ready = 1'b1;
        Inst = 32'h0;
        #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall();
        test_branch(32'h1421_0003, 1'b1);   // bne
        test_branch(32'h1021_0003, 1'b0);   // beq
        test_rtype();
        test_itype();
        test_jal();
        test_illegal();
        test_reset_mid();
`ifdef M_USEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
